// File: rtl/cache_pkg.sv
// Shared types and block geometry for the cache/memory arbiter.
// A block is 8 x 16-bit words; a byte address splits into base[15:4] / word[3:1] / byte[0].
package cache_pkg;

  localparam int BLOCK_WORDS  = 8;
  localparam int WORD_OFS_W   = 3;
  localparam int BLOCK_BASE_W = 12;
  localparam int CNT_W        = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/fill_counter.sv
// Block-word counter used for both read issue and data receive during a fill.
// Counts 0..BLOCK_WORDS; o_done holds once all words of the block are counted.
module fill_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == CNT_W'(BLOCK_WORDS));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Serialises I/D block fills and D write-through stores onto one pipelined memory.
// Stores issue combinationally from IDLE; fills issue 8 back-to-back reads and stream words back.
module cache_mem_arbiter
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icache_miss,
  input  logic [15:0] icache_miss_addr,
  input  logic        dcache_miss,
  input  logic [15:0] dcache_miss_addr,
  input  logic        dcache_wr_req,
  input  logic [15:0] dcache_wr_addr,
  input  logic [15:0] dcache_wr_data,
  output logic        dcache_wr_ack,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        icache_fill_we,
  output logic        dcache_fill_we,
  output logic        icache_tag_we,
  output logic        dcache_tag_we,
  output logic        busy
);

  arb_state_t              r_state;
  owner_t                  r_owner;
  logic [BLOCK_BASE_W-1:0] r_base;
  logic [15:0]             r_fill_data;
  logic [WORD_OFS_W-1:0]   r_fill_word;
  logic                    r_ifill_we, r_dfill_we, r_itag_we, r_dtag_we;

  logic [CNT_W-1:0] w_issue_cnt, w_recv_cnt;
  logic             w_issue_done, w_recv_done;
  logic             w_idle, w_fill, w_store, w_grant, w_issue, w_recv, w_last, w_cnt_clear;
  logic             w_unused;

  assign w_idle      = (r_state == IDLE);
  assign w_fill      = (r_state == FILL);
  // The store path is combinational, so gate it with rst_n to keep outputs quiet in reset.
  assign w_store     = w_idle && dcache_wr_req && rst_n;
  assign w_grant     = w_idle && !dcache_wr_req && (dcache_miss || icache_miss);
  assign w_issue     = w_fill && !w_issue_done;
  assign w_recv      = w_fill && mem_data_valid && !w_recv_done;
  assign w_last      = w_recv && (w_recv_cnt == CNT_W'(BLOCK_WORDS - 1));
  assign w_cnt_clear = w_grant || (w_fill && w_recv_done);

  fill_counter u_issue_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_cnt_clear),
    .i_inc   (w_issue),
    .o_count (w_issue_cnt),
    .o_done  (w_issue_done)
  );

  fill_counter u_recv_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_cnt_clear),
    .i_inc   (w_recv),
    .o_count (w_recv_cnt),
    .o_done  (w_recv_done)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_store) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = dcache_wr_addr;
      mem_wdata = dcache_wr_data;
    end else if (w_issue) begin
      mem_en   = 1'b1;
      mem_addr = {r_base, w_issue_cnt[WORD_OFS_W-1:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= OWN_I;
      r_base  <= '0;
    end else if (w_grant) begin
      r_state <= FILL;
      r_owner <= dcache_miss ? OWN_D : OWN_I;
      r_base  <= dcache_miss ? dcache_miss_addr[15:4] : icache_miss_addr[15:4];
    end else if (w_fill && w_recv_done) begin
      r_state <= IDLE;
    end
  end

  // Fill strobes are registered one cycle behind mem_data_valid, alongside the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_data <= '0;
      r_fill_word <= '0;
      r_ifill_we  <= 1'b0;
      r_dfill_we  <= 1'b0;
      r_itag_we   <= 1'b0;
      r_dtag_we   <= 1'b0;
    end else begin
      r_ifill_we <= w_recv && (r_owner == OWN_I);
      r_dfill_we <= w_recv && (r_owner == OWN_D);
      r_itag_we  <= w_last && (r_owner == OWN_I);
      r_dtag_we  <= w_last && (r_owner == OWN_D);
      if (w_recv) begin
        r_fill_data <= mem_rdata;
        r_fill_word <= w_recv_cnt[WORD_OFS_W-1:0];
      end
    end
  end

  assign dcache_wr_ack  = w_store;
  assign busy           = w_fill;
  assign fill_data      = r_fill_data;
  assign fill_word      = r_fill_word;
  assign icache_fill_we = r_ifill_we;
  assign dcache_fill_we = r_dfill_we;
  assign icache_tag_we  = r_itag_we;
  assign dcache_tag_we  = r_dtag_we;

  // Byte/word offset of miss addresses is irrelevant: fills always start at word 0.
  assign w_unused = ^{icache_miss_addr[3:0], dcache_miss_addr[3:0], w_issue_cnt[CNT_W-1]};

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench: a timeline model (cycles since grant) predicts every output each cycle,
// a 4-cycle pipelined memory answers reads, and directed literals pin the model.
module tb_cache_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        icache_miss, dcache_miss, dcache_wr_req;
  logic [15:0] icache_miss_addr, dcache_miss_addr, dcache_wr_addr, dcache_wr_data;
  logic        dcache_wr_ack, mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic        mem_data_valid;
  logic [2:0]  fill_word;
  logic        icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we, busy;

  cache_mem_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .icache_miss      (icache_miss),
    .icache_miss_addr (icache_miss_addr),
    .dcache_miss      (dcache_miss),
    .dcache_miss_addr (dcache_miss_addr),
    .dcache_wr_req    (dcache_wr_req),
    .dcache_wr_addr   (dcache_wr_addr),
    .dcache_wr_data   (dcache_wr_data),
    .dcache_wr_ack    (dcache_wr_ack),
    .mem_en           (mem_en),
    .mem_wr           (mem_wr),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_data_valid   (mem_data_valid),
    .fill_data        (fill_data),
    .fill_word        (fill_word),
    .icache_fill_we   (icache_fill_we),
    .dcache_fill_we   (dcache_fill_we),
    .icache_tag_we    (icache_tag_we),
    .dcache_tag_we    (dcache_tag_we),
    .busy             (busy)
  );

  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] mem_key = 16'h0000;
  logic        ret_v [16];
  logic [15:0] ret_d [16];
  logic        inject_stray = 1'b0;
  logic [15:0] stray_data = 16'h0000;

  // Reference model: a fill is fully described by its grant cycle, owner and block base.
  int          fill_t0 = -1;
  logic        m_own_d = 1'b0;
  logic [11:0] m_base = 12'h000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    return a ^ mem_key;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory: a read seen in cycle c returns its data in cycle c+4.
  initial begin
    mem_data_valid = 1'b0;
    mem_rdata      = 16'h0000;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      mem_data_valid = ret_v[cyc % 16] || inject_stray;
      mem_rdata      = ret_v[cyc % 16] ? ret_d[cyc % 16] : stray_data;
    end
  end

  task automatic model_step();
    int         c;
    int         phase;
    logic       m_busy, m_store, m_fw;
    logic [2:0] w;
    c = cyc;
    ret_v[c % 16] = 1'b0;
    if (!rst_n) begin
      fill_t0 = -1;
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_fill_data", fill_data, 0);
      check("rst_fill_word", fill_word, 0);
      check("rst_strobes", {icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we}, 0);
      check("rst_ack", dcache_wr_ack, 0);
      check("rst_busy", busy, 0);
      return;
    end
    phase   = c - fill_t0;
    m_busy  = (fill_t0 >= 0) && (phase >= 1) && (phase <= 13);
    m_store = !m_busy && dcache_wr_req;
    check("mem_en", mem_en, m_store || (m_busy && phase <= 8));
    check("mem_wr", mem_wr, m_store);
    check("wr_ack", dcache_wr_ack, m_store);
    check("busy", busy, m_busy);
    if (m_store) begin
      check("st_addr", mem_addr, dcache_wr_addr);
      check("st_wdata", mem_wdata, dcache_wr_data);
    end else if (m_busy && phase <= 8) begin
      w = 3'(phase - 1);
      check("rd_addr", mem_addr, {m_base, w, 1'b0});
    end
    m_fw = m_busy && (phase >= 6);
    check("i_fill_we", icache_fill_we, m_fw && !m_own_d);
    check("d_fill_we", dcache_fill_we, m_fw && m_own_d);
    check("i_tag_we", icache_tag_we, m_busy && phase == 13 && !m_own_d);
    check("d_tag_we", dcache_tag_we, m_busy && phase == 13 && m_own_d);
    if (m_fw) begin
      w = 3'(phase - 6);
      check("fill_word", fill_word, w);
      check("fill_data", fill_data, mem_read({m_base, w, 1'b0}));
    end
    if (!m_busy && !m_store && (dcache_miss || icache_miss)) begin
      fill_t0 = c;
      m_own_d = dcache_miss;
      m_base  = dcache_miss ? dcache_miss_addr[15:4] : icache_miss_addr[15:4];
    end
    if (mem_en && !mem_wr) begin
      ret_v[(c + 4) % 16] = 1'b1;
      ret_d[(c + 4) % 16] = mem_read(mem_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ret_v[i] = 1'b0;
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  initial begin
    logic i_pend, d_pend, w_pend;
    int   ph;
    icache_miss = 0; dcache_miss = 0; dcache_wr_req = 0;
    icache_miss_addr = 0; dcache_miss_addr = 0; dcache_wr_addr = 0; dcache_wr_data = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    go(3);
    rst_n = 1'b1;
    go(2);

    // Single I-miss, memory word = address.
    go(1); icache_miss = 1; icache_miss_addr = 16'h1236;
    go(1); @(negedge clk);
    check("t1_rd_en", mem_en, 1);
    check("t1_rd_addr0", mem_addr, 16'h1230);
    go(7); @(negedge clk);
    check("t1_rd_addr7", mem_addr, 16'h123E);
    go(5); @(negedge clk);
    check("t1_itag_T13", icache_tag_we, 1);
    check("t1_data7", fill_data, 16'h123E);
    check("t1_dfill_quiet", dcache_fill_we, 0);
    go(1); icache_miss = 0; @(negedge clk);
    check("t1_idle_T14", busy, 0);

    // D and I miss together: D first, I granted at T14.
    go(2);
    go(1); dcache_miss = 1; dcache_miss_addr = 16'h4000; icache_miss = 1; icache_miss_addr = 16'h0010;
    go(13); @(negedge clk);
    check("t2_dtag_T13", dcache_tag_we, 1);
    go(1); dcache_miss = 0;
    go(1); @(negedge clk);
    check("t2_i_rd_T15", mem_addr, 16'h0010);
    go(12); @(negedge clk);
    check("t2_itag_T27", icache_tag_we, 1);
    go(1); icache_miss = 0;

    // Store raised mid-fill waits for IDLE.
    go(2);
    go(1); dcache_miss = 1; dcache_miss_addr = 16'h3000;
    go(3); dcache_wr_req = 1; dcache_wr_addr = 16'h2002; dcache_wr_data = 16'hBEEF;
    @(negedge clk);
    check("t3_no_ack_fill", dcache_wr_ack, 0);
    go(11); dcache_miss = 0; @(negedge clk);
    check("t3_st_wr", {mem_en, mem_wr, dcache_wr_ack}, 3'b111);
    check("t3_st_addr", mem_addr, 16'h2002);
    check("t3_st_wdata", mem_wdata, 16'hBEEF);
    go(1); dcache_wr_req = 0;

    // Store and D-miss together in IDLE.
    go(2);
    go(1); dcache_wr_req = 1; dcache_wr_addr = 16'h0A0C; dcache_wr_data = 16'h1234;
    dcache_miss = 1; dcache_miss_addr = 16'h7770;
    @(negedge clk);
    check("t4_ack_c0", dcache_wr_ack, 1);
    go(1); dcache_wr_req = 0; @(negedge clk);
    check("t4_no_rd_c1", mem_en, 0);
    go(1); @(negedge clk);
    check("t4_rd_c2", mem_addr, 16'h7770);
    go(13); dcache_miss = 0;

    // Reset mid-fill, stray returns, then a normal fill.
    go(2);
    go(1); icache_miss = 1; icache_miss_addr = 16'h5550;
    go(7); rst_n = 0; icache_miss = 0; @(negedge clk);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_mem_en", mem_en, 0);
    go(2); rst_n = 1;
    go(3); inject_stray = 1; stray_data = 16'hDEAD;
    go(1); inject_stray = 0; @(negedge clk);
    check("t5_stray_ignored", icache_fill_we, 0);
    go(3);
    go(1); icache_miss = 1; icache_miss_addr = 16'h6660;
    go(13); @(negedge clk);
    check("t5_refill_tag", icache_tag_we, 1);
    check("t5_refill_data", fill_data, 16'h666E);
    go(1); icache_miss = 0;

    // Miss dropped at T4: fill still completes.
    go(2);
    go(1); icache_miss = 1; icache_miss_addr = 16'h0ABC;
    go(4); icache_miss = 0;
    go(9); @(negedge clk);
    check("t6_tag_T13", icache_tag_we, 1);
    check("t6_word7", fill_word, 3'd7);
    check("t6_data7", fill_data, 16'h0ABE);

    // Randomised traffic against the model.
    go(3);
    mem_key = 16'($urandom);
    i_pend = 0; d_pend = 0; w_pend = 0;
    for (int k = 0; k < 800; k++) begin
      go(1);
      if (!w_pend && $urandom_range(0, 3) == 0) begin
        w_pend = 1; dcache_wr_addr = 16'($urandom); dcache_wr_data = 16'($urandom);
      end
      if (!d_pend && $urandom_range(0, 15) == 0) begin
        d_pend = 1; dcache_miss_addr = 16'($urandom);
      end
      if (!i_pend && $urandom_range(0, 15) == 0) begin
        i_pend = 1; icache_miss_addr = 16'($urandom);
      end
      if (i_pend && $urandom_range(0, 63) == 0) i_pend = 0;
      if (d_pend && $urandom_range(0, 63) == 0) d_pend = 0;
      dcache_wr_req = w_pend; dcache_miss = d_pend; icache_miss = i_pend;
      ph = cyc - fill_t0;
      inject_stray = ((fill_t0 < 0) || (ph < 1) || (ph > 13)) && ($urandom_range(0, 15) == 0);
      stray_data = 16'($urandom);
      @(negedge clk);
      if (dcache_wr_ack) w_pend = 0;
      if (dcache_tag_we) d_pend = 0;
      if (icache_tag_we) i_pend = 0;
    end
    go(1);
    inject_stray = 0; dcache_wr_req = 0; dcache_miss = 0; icache_miss = 0;
    go(20);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
